// File: rtl/fsm_sequence_generator.sv
// Bit-serial MSB-first word transmitter with optional idle gap and a saturating frame counter.
// Define SEQGEN_PARITY_EN to append an even-parity bit after the data bits of every frame.
module fsm_sequence_generator #(
  parameter int WIDTH = 4,
  parameter int GAP   = 0,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] frame_count
);

`ifdef SEQGEN_PARITY_EN
  localparam int FBITS = WIDTH + 1;
`else
  localparam int FBITS = WIDTH;
`endif
  localparam int              BCW      = $clog2(FBITS);
  localparam logic [BCW-1:0]  BIT_LAST = BCW'(FBITS - 1);
  localparam logic [7:0]      GAP_LAST = 8'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t             r_state;
  logic [FBITS-1:0]   r_shreg;
  logic [BCW-1:0]     r_bitcnt;
  logic [7:0]         r_gapcnt;
  logic               r_out;
  logic               r_out_valid;
  logic               r_busy;
  logic               r_done;
  logic [CNT_W-1:0]   r_frame_count;

  state_t             w_state_nxt;
  logic [FBITS-1:0]   w_shreg_nxt;
  logic [BCW-1:0]     w_bitcnt_nxt;
  logic [7:0]         w_gapcnt_nxt;
  logic               w_out_nxt;
  logic               w_done_nxt;
  logic [CNT_W-1:0]   w_frame_nxt;
  logic [FBITS-1:0]   w_load_word;
  logic               w_accept;

  assign load_ready = (r_state == S_IDLE) && rst;
  assign w_accept   = load_valid && load_ready;

`ifdef SEQGEN_PARITY_EN
  assign w_load_word = {load_data, ^load_data};
`else
  assign w_load_word = load_data;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_shreg_nxt  = r_shreg;
    w_bitcnt_nxt = r_bitcnt;
    w_gapcnt_nxt = r_gapcnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_shreg_nxt  = w_load_word;
          w_bitcnt_nxt = BIT_LAST;
          w_state_nxt  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_shreg_nxt = r_shreg << 1;
        if (r_bitcnt == '0) begin
          w_state_nxt  = (GAP > 0) ? S_GAP : S_IDLE;
          w_gapcnt_nxt = GAP_LAST;
        end else begin
          w_bitcnt_nxt = r_bitcnt - BCW'(1);
        end
      end
      S_GAP: begin
        if (r_gapcnt == '0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_gapcnt_nxt = r_gapcnt - 8'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they line up with the state they describe.
  always_comb begin
    w_out_nxt   = (w_state_nxt == S_SHIFT) && w_shreg_nxt[FBITS-1];
    w_done_nxt  = (w_state_nxt == S_SHIFT) && (w_bitcnt_nxt == '0);
    w_frame_nxt = r_frame_count;
    if (w_done_nxt && (r_frame_count != CNT_MAX)) begin
      w_frame_nxt = r_frame_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_shreg       <= '0;
      r_bitcnt      <= '0;
      r_gapcnt      <= '0;
      r_out         <= 1'b0;
      r_out_valid   <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_shreg       <= w_shreg_nxt;
      r_bitcnt      <= w_bitcnt_nxt;
      r_gapcnt      <= w_gapcnt_nxt;
      r_out         <= w_out_nxt;
      r_out_valid   <= (w_state_nxt == S_SHIFT);
      r_busy        <= (w_state_nxt != S_IDLE);
      r_done        <= w_done_nxt;
      r_frame_count <= w_frame_nxt;
    end
  end

  assign out         = r_out;
  assign out_valid   = r_out_valid;
  assign busy        = r_busy;
  assign done        = r_done;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_fsm_sequence_generator.sv
// Bench for fsm_sequence_generator: scoreboarded serial stream plus directed timing checks.
module tb_fsm_sequence_generator;

`ifdef SEQGEN_PARITY_EN
  localparam int FB = 5;
`else
  localparam int FB = 4;
`endif

  logic       clk = 1'b0;
  logic       rst0, lv0, lr0, o0, ov0, bz0, dn0;
  logic [3:0] ld0;
  logic [1:0] fc0;
  logic       rst1, lv1, lr1, o1, ov1, bz1, dn1;
  logic [3:0] ld1;
  logic [7:0] fc1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fsm_sequence_generator #(.WIDTH(4), .GAP(0), .CNT_W(2)) u_dut0 (
    .clk(clk), .rst(rst0), .load_valid(lv0), .load_data(ld0), .load_ready(lr0),
    .out(o0), .out_valid(ov0), .busy(bz0), .done(dn0), .frame_count(fc0)
  );

  fsm_sequence_generator #(.WIDTH(4), .GAP(3), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst(rst1), .load_valid(lv1), .load_data(ld1), .load_ready(lr1),
    .out(o1), .out_valid(ov1), .busy(bz1), .done(dn1), .frame_count(fc1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [FB-1:0] ext(input logic [3:0] w);
`ifdef SEQGEN_PARITY_EN
    return {w, ^w};
`else
    return w;
`endif
  endfunction

  // Scoreboard for u_dut0: each accepted word pushes its expected serial bits.
  typedef struct packed {
    logic       b;
    logic       last;
    logic [1:0] cnt;
  } exp_t;
  exp_t       q0[$];
  logic [1:0] m_cnt0 = 2'd0;

  always @(posedge clk) begin
    if (!rst0) begin
      q0.delete();
      m_cnt0 = 2'd0;
    end else if (lv0 && lr0) begin
      logic [FB-1:0] e;
      e = ext(ld0);
      if (m_cnt0 != 2'd3) m_cnt0 = m_cnt0 + 2'd1;
      for (int i = 0; i < FB; i++) q0.push_back('{b: e[FB-1-i], last: (i == FB-1), cnt: m_cnt0});
    end
  end

  always @(negedge clk) begin
    exp_t x;
    if (ov0 === 1'b1) begin
      chk("sb_underflow", 32'(q0.size() != 0), 1);
      if (q0.size() != 0) begin
        x = q0.pop_front();
        chk("sb_out", o0, x.b);
        chk("sb_done", dn0, x.last);
        if (x.last) chk("sb_count", fc0, x.cnt);
      end
    end else begin
      chk("sb_done_idle", dn0, 0);
    end
  end

  task automatic send0(input logic [3:0] w, input logic [31:0] exp_fc);
    logic [FB-1:0] e;
    e = ext(w);
    chk("s0_ready", lr0, 1);
    lv0 = 1'b1;
    ld0 = w;
    tick();
    lv0 = 1'b0;
    ld0 = ~w;
    for (int k = 0; k < FB; k++) begin
      chk("s0_out", o0, e[FB-1-k]);
      chk("s0_vld", ov0, 1);
      chk("s0_busy", bz0, 1);
      chk("s0_lr", lr0, 0);
      chk("s0_done", dn0, 32'(k == FB-1));
      if (k == FB-1) chk("s0_cnt", fc0, exp_fc);
      tick();
    end
    chk("s0_idle_vld", ov0, 0);
    chk("s0_idle_out", o0, 0);
    chk("s0_idle_busy", bz0, 0);
    chk("s0_idle_lr", lr0, 1);
  endtask

  initial begin
    #100000;
    $error("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FB-1:0] ea, eb, e1;
    logic          ev, eo;
    rst0 = 1'b0; lv0 = 1'b0; ld0 = 4'd0;
    rst1 = 1'b0; lv1 = 1'b0; ld1 = 4'd0;
    tick();
    tick();
    chk("rst_vld", ov0, 0);
    chk("rst_out", o0, 0);
    chk("rst_busy", bz0, 0);
    chk("rst_done", dn0, 0);
    chk("rst_cnt", fc0, 0);
    chk("rst_lr_in_reset", lr0, 0);
    rst0 = 1'b1;
    rst1 = 1'b1;
    #1;
    chk("rst_lr_release", lr0, 1);
    chk("rst_lr_release1", lr1, 1);

    // Single frames; 1001 exercises a zero parity bit when parity is enabled.
    send0(4'b1011, 1);
    send0(4'b1001, 2);
    for (int i = 0; i < 3; i++) begin
      chk("idle_hold_vld", ov0, 0);
      chk("idle_hold_out", o0, 0);
      tick();
    end

    // Back-to-back with load_valid held high.
    rst0 = 1'b0;
    tick();
    rst0 = 1'b1;
    lv0 = 1'b1;
    ld0 = 4'b1011;
    tick();
    ld0 = 4'b0110;
    ea = ext(4'b1011);
    eb = ext(4'b0110);
    for (int i = 0; i < 2*FB+1; i++) begin
      if (i < FB) begin
        ev = 1'b1; eo = ea[FB-1-i];
      end else if (i == FB) begin
        ev = 1'b0; eo = 1'b0;
      end else begin
        ev = 1'b1; eo = eb[2*FB-i];
      end
      chk("b2b_vld", ov0, ev);
      chk("b2b_out", o0, eo);
      chk("b2b_lr", lr0, 32'(i == FB));
      chk("b2b_done", dn0, 32'(i == FB-1 || i == 2*FB));
      if (i == FB-1) chk("b2b_cnt1", fc0, 1);
      if (i == 2*FB) chk("b2b_cnt2", fc0, 2);
      if (i == FB+1) lv0 = 1'b0;
      tick();
    end
    chk("b2b_end_busy", bz0, 0);

    // Reset on the second serial bit aborts the frame.
    lv0 = 1'b1;
    ld0 = 4'b1011;
    tick();
    lv0 = 1'b0;
    chk("abort_bit1_vld", ov0, 1);
    tick();
    chk("abort_bit2_vld", ov0, 1);
    chk("abort_bit2_out", o0, 0);
    rst0 = 1'b0;
    tick();
    chk("abort_vld", ov0, 0);
    chk("abort_busy", bz0, 0);
    chk("abort_done", dn0, 0);
    chk("abort_cnt", fc0, 0);
    chk("abort_lr_in_reset", lr0, 0);
    rst0 = 1'b1;
    #1;
    chk("abort_lr_release", lr0, 1);
    for (int i = 0; i < 6; i++) begin
      chk("abort_no_done", dn0, 0);
      chk("abort_no_vld", ov0, 0);
      tick();
    end

    // Saturation at 2^CNT_W-1 = 3.
    for (int f = 0; f < 5; f++) begin
      send0(4'(f * 5 + 3), (f + 1 > 3) ? 3 : f + 1);
    end

    // GAP=3 instance, load_valid held to find the earliest re-acceptance.
    e1 = ext(4'b1111);
    lv1 = 1'b1;
    ld1 = 4'b1111;
    chk("gap_lr0", lr1, 1);
    tick();
    for (int i = 1; i <= FB+5; i++) begin
      chk("gap_vld", ov1, 32'(i <= FB || i == FB+5));
      chk("gap_busy", bz1, 32'(i != FB+4));
      chk("gap_lr", lr1, 32'(i == FB+4));
      chk("gap_done", dn1, 32'(i == FB));
      if (i <= FB) chk("gap_out", o1, e1[FB-i]);
      else if (i == FB+5) chk("gap_out2", o1, e1[FB-1]);
      else chk("gap_out_idle", o1, 0);
      if (i == FB) chk("gap_cnt1", fc1, 1);
      if (i == FB+5) lv1 = 1'b0;
      else tick();
    end
    repeat (FB-1) tick();
    chk("gap_done2", dn1, 1);
    chk("gap_cnt2", fc1, 2);

    tick();
    chk("sb_empty", q0.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fsm_sequence_generator.md
Name: fsm_sequence_generator

Overview:
- Bit-serial pattern transmitter; the transmit-side counterpart of the team's serial sequence detector.
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out MSB-first, one bit per clock, on a single serial line.
- Optionally inserts idle gap cycles between frames. Counts completed frames.
- Drives stimulus into the sequence detector (e.g. 1011) in self-checking FSM testbenches and timing-characterisation designs.

Parameters:
- WIDTH, 4, frame length in bits (2..32).
- GAP, 0, idle cycles inserted after each frame before returning to IDLE (0..255).
- CNT_W, 8, width of the saturating frame counter.

Ports:
- clk  input  1  single clock, all logic on rising edge.
- rst  input  1  synchronous, active-low reset (sampled on rising clk; 0 = reset).
- load_valid  input  1  load_data is valid.
- load_data  input  WIDTH  word to transmit; bit WIDTH-1 goes first.
- load_ready  output  1  generator can accept a word.
- out  output  1  serial data bit.
- out_valid  output  1  out carries a frame bit this cycle.
- busy  output  1  state is not IDLE.
- done  output  1  one-cycle pulse coincident with the final serial bit of a frame.
- frame_count  output  CNT_W  number of completed frames, saturating.

Behaviour:
- Reset (rst==0 at a clk edge): state=IDLE, shift register=0, bit counter=0, gap counter=0.
  - Outputs after reset: out=0, out_valid=0, busy=0, done=0, frame_count=0.
  - load_ready=1 from the first cycle with rst==1.
  - Reset wins over every other event, including mid-frame. A frame in progress is aborted, with no done pulse and no count.
- All outputs are registered except load_ready. load_ready is combinational: it is 1 exactly when state==IDLE and rst==1.
- States:
  - IDLE: out_valid=0, out=0. On load_valid&&load_ready: capture load_data, set bit counter=WIDTH-1, go to SHIFT.
  - SHIFT: out=shreg[WIDTH-1], out_valid=1, shift left by one each cycle, decrement the counter. The first bit appears the cycle after the handshake (latency 1).
    - On the final bit (counter==0): done=1, frame_count increments, saturating at 2^CNT_W-1 (no wrap).
    - Next state after the final bit: GAP if GAP>0, else IDLE.
  - GAP: out=0, out_valid=0, busy=1. Held for exactly GAP cycles, then IDLE.
- Throughput: one frame per WIDTH+GAP+1 cycles; the IDLE cycle is mandatory between frames.
- load_valid while not IDLE is ignored. load_data is not sampled, and the word is not queued.
- load_valid deasserted in IDLE: the generator stays in IDLE indefinitely with out=0.
- load_data is sampled only on the handshake cycle. Later changes do not affect the frame in flight.
- Next-state logic has a default branch: any unreachable state encoding returns to IDLE.

Optional Feature:
- Macro: SEQGEN_PARITY_EN.
- Defined: after the WIDTH data bits, one extra SHIFT cycle transmits the even-parity bit (XOR of the captured word), with out_valid=1.
  - done and the frame_count increment move to the parity-bit cycle.
  - Frame period becomes WIDTH+GAP+2.
- Undefined: no parity bit. Frame is exactly WIDTH bits as described above.

Test Plan:
- Reset then load 4'b1011 with GAP=0.
  - Handshake at cycle T.
  - out=1,0,1,1 with out_valid=1 at T+1..T+4.
  - done=1 only at T+4; frame_count=1.
  - load_ready=1 again at T+5.
- Back-to-back loads 4'b1011 then 4'b0110 with load_valid held high.
  - Serial stream 1,0,1,1,idle,0,1,1,0.
  - frame_count=2.
  - Second word is not taken before the IDLE cycle.
- GAP=3, load 4'b1111.
  - Four valid 1-bits, then 3 cycles with out_valid=0 and busy=1, then IDLE.
  - Next handshake accepted no earlier than 8 cycles after the first.
- Drive rst=0 at the 2nd serial bit of a frame.
  - Next cycle: out_valid=0, busy=0, done never pulses, frame_count=0.
- CNT_W=2: send 5 frames -> frame_count reads 1,2,3,3,3 (saturation).
- With SEQGEN_PARITY_EN, load 4'b1011.
  - out=1,0,1,1,1 (parity bit 1).
  - done on the 5th bit.
  - 4'b1001 yields parity bit 0.
